// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   typedef logic [1:0] byte_idx_t;

   localparam int unsigned DATA_BITS      = 8;
   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, bit FSM and bit timer; emits one-cycle
// byte_ok / byte_err pulses with the received byte on byte_data.
//
// state | meaning
// IDLE  | line idle, waiting for a low rx_s (only once armed)
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample 8 data bits, LSB first, one per bit period
// STOP  | sample the stop bit one bit period later, report ok/err
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_ok,
   output logic       byte_err,
   output logic       idle,
   output logic       start_det
);

   localparam int unsigned    TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

   rx_state_t       state, state_nxt;
   logic [1:0]      sync;
   logic [1:0]      fill;
   logic            armed;
   logic            rx_s;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            timer_clr, shift_en, bit_clr, done_ok, done_err;

   assign rx_s = sync[1];

   // The synchronizer resets high, so its reset value must not count as a
   // genuine idle line: arm only once a real high level has propagated through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         fill  <= 2'b00;
         armed <= 1'b0;
      end else begin
         sync <= {sync[0], rx};
         fill <= {fill[0], 1'b1};
         if (fill[1] && rx_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      shift_en  = 1'b0;
      bit_clr   = 1'b0;
      done_ok   = 1'b0;
      done_err  = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !rx_s) begin
               state_nxt = START;
               timer_clr = 1'b1;
            end
         end
         START: begin
            if (timer == HALF_LAST) begin
               timer_clr = 1'b1;
               bit_clr   = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_clr = 1'b1;
               shift_en  = 1'b1;
               if (bit_cnt == LAST_BIT)
                  state_nxt = STOP;
            end
         end
         STOP: begin
            if (timer == BIT_LAST) begin
               timer_clr = 1'b1;
               state_nxt = IDLE;
               done_ok   = rx_s;
               done_err  = !rx_s;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;
      end else begin
         if (timer_clr || state == IDLE)
            timer <= '0;
         else
            timer <= timer + TW'(1);
         if (bit_clr)
            bit_cnt <= '0;
         else if (shift_en)
            bit_cnt <= bit_cnt + 3'd1;
         if (shift_en)
            shreg <= {rx_s, shreg[7:1]};
         byte_ok  <= done_ok;
         byte_err <= done_err;
      end
   end

   assign byte_data = shreg;
   assign idle      = (state == IDLE);
   assign start_det = (state == IDLE) && armed && !rx_s;

endmodule

// File: rtl/uart_word_rx.sv
// Assembles four received UART bytes (little-endian) into a 32-bit word and
// drops a partial word after an over-long idle gap.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned TIMEOUT_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [31:0] word_out,
   output logic        word_valid,
   output logic        frame_err,
   output byte_idx_t   byte_idx
);

   localparam int unsigned   GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned   GW        = $clog2(GAP_LIMIT + 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIMIT - 1);
   localparam byte_idx_t     LAST_IDX  = byte_idx_t'(BYTES_PER_WORD - 1);

   logic [7:0]    byte_data;
   logic          byte_ok, byte_err, idle, start_det;
   logic [23:0]   partial;
   logic [GW-1:0] gap;
   logic          gap_active, timeout;

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .byte_data (byte_data),
      .byte_ok   (byte_ok),
      .byte_err  (byte_err),
      .idle      (idle),
      .start_det (start_det)
   );

   assign gap_active = idle && (byte_idx != 2'd0);
   // A start edge coinciding with expiry still clears the index, so that byte lands in lane 0.
   assign timeout    = gap_active && (gap == GAP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         byte_idx   <= '0;
         partial    <= '0;
         gap        <= '0;
      end else begin
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (byte_err) begin
            frame_err <= 1'b1;
            byte_idx  <= '0;
         end else if (byte_ok) begin
            if (byte_idx == LAST_IDX) begin
               word_out   <= {byte_data, partial};
               word_valid <= 1'b1;
               byte_idx   <= '0;
            end else begin
               case (byte_idx)
                  2'd0:    partial[7:0]   <= byte_data;
                  2'd1:    partial[15:8]  <= byte_data;
                  2'd2:    partial[23:16] <= byte_data;
                  default: ;
               endcase
               byte_idx <= byte_idx + 2'd1;
            end
         end else if (timeout) begin
            byte_idx <= '0;
         end

         if (!gap_active || start_det || timeout)
            gap <= '0;
         else
            gap <= gap + GW'(1);
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: expected words/errors go into a queue when
// stimulus is issued; a monitor pops and compares on every output pulse.
module tb_uart_word_rx;
   import uart_pkg::*;

   localparam int CPB = 4;

   typedef struct {
      logic        is_err;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [31:0] word_out;
   logic        word_valid;
   logic        frame_err;
   byte_idx_t   byte_idx;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   uart_word_rx #(
      .CLKS_PER_BIT (4),
      .TIMEOUT_BITS (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .byte_idx   (byte_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_valid && frame_err) begin
         vectors++;
         miscompares++;
         $display("FAIL pulse_overlap: word_valid=1 frame_err=1, required not both");
      end else if (word_valid || frame_err) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: word_valid=%0b frame_err=%0b word_out=%h, required no pulse",
                     word_valid, frame_err, word_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_err != frame_err) begin
               miscompares++;
               $display("FAIL pulse_kind: frame_err=%0b, required %0b", frame_err, e.is_err);
            end else if (!e.is_err && word_out !== e.word) begin
               miscompares++;
               $display("FAIL word_out: got %h, required %h", word_out, e.word);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      cycles(n * CPB);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_b);
      rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cycles(CPB);
      end
      rx = stop_b;
      cycles(CPB);
      rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      exp_t e;
      e.is_err = 1'b0;
      e.word   = w;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++)
         send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s: %0d expected pulses still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idx(input string name, input logic [1:0] exp);
      @(negedge clk);
      chk(name, {30'd0, byte_idx}, {30'd0, exp});
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_word_out",   word_out,          32'h0);
      chk("reset_word_valid", {31'd0, word_valid}, 32'h0);
      chk("reset_frame_err",  {31'd0, frame_err},  32'h0);
      chk("reset_byte_idx",   {30'd0, byte_idx},   32'h0);
      rst = 1'b0;
      idle_bits(2);

      send_word(32'h1234_5678);
      drain("word_12345678");
      check_idx("idx_after_word", 2'd0);

      send_word(32'h0000_0000);
      drain("word_zero");
      send_word(32'hFFFF_FFFF);
      drain("word_ones");
      cycles(10);
      @(negedge clk);
      chk("word_hold", word_out, 32'hFFFF_FFFF);

      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      cycles(4);
      check_idx("idx_two_bytes", 2'd2);
      e.is_err = 1'b1;
      e.word   = 32'h0;
      exp_q.push_back(e);
      send_byte(8'h33, 1'b0);
      idle_bits(2);
      drain("frame_err_pulse");
      check_idx("idx_after_ferr", 2'd0);
      send_word(32'hDDCC_BBAA);
      drain("word_ddccbbaa");

      rx = 1'b0;
      cycles(1);
      rx = 1'b1;
      idle_bits(4);
      check_idx("idx_after_glitch", 2'd0);
      @(negedge clk);
      chk("word_after_glitch", word_out, 32'hDDCC_BBAA);

      send_byte(8'hEE, 1'b1);
      send_byte(8'hEF, 1'b1);
      cycles(4);
      check_idx("idx_before_gap", 2'd2);
      idle_bits(20);
      check_idx("idx_after_timeout", 2'd0);
      send_word(32'h0403_0201);
      drain("word_04030201");

      send_byte(8'h9A, 1'b1);
      send_byte(8'hBC, 1'b1);
      send_byte(8'hDE, 1'b1);
      rx = 1'b0;
      cycles(CPB);
      rx = 1'b1;
      cycles(CPB);
      rx = 1'b0;
      cycles(2 * CPB);
      rst = 1'b1;
      rx  = 1'b1;
      cycles(2);
      @(negedge clk);
      chk("midrst_word_out", word_out,            32'h0);
      chk("midrst_pulses",   {30'd0, word_valid, frame_err}, 32'h0);
      chk("midrst_byte_idx", {30'd0, byte_idx},   32'h0);
      rst = 1'b0;
      idle_bits(2);
      check_idx("idx_after_release", 2'd0);
      send_word(32'h55AA_33CC);
      drain("word_after_reset");

      rx  = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(12 * CPB);
      check_idx("idx_low_line", 2'd0);
      @(negedge clk);
      chk("word_low_line", word_out, 32'h0);
      idle_bits(2);
      send_word(32'h8765_4321);
      drain("word_after_low_line");

      idle_bits(2);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

endmodule
